// File: rtl/led_seq_pkg.sv
// LED sequencer shared definitions: FSM state encoding, LED mode codes,
// and the step-to-LED pattern mapping.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BINARY = 2'd0;
    localparam logic [1:0] MODE_ANDOR  = 2'd1;
    localparam logic [1:0] MODE_WALK   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // LED drive for a given pattern mode and step counter value.
    function automatic logic [1:0] led_pattern(input logic [1:0] m, input logic [1:0] s);
        logic [1:0] p;
        case (m)
            MODE_BINARY: p = s;
            MODE_ANDOR:  p = {s[1] & s[0], s[1] | s[0]};
            MODE_WALK:   p = s[0] ? 2'b10 : 2'b01;
            default:     p = s[0] ? 2'b11 : 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler with a selectable-length terminal compare.
// tick fires while enabled when the low DIV_BASE+div bits are all ones,
// so the first tick lands 2^(DIV_BASE+div) enabled cycles after a clear.
module led_prescaler #(
    parameter int CNT_W    = 28,
    parameter int DIV_BASE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] div,
    output logic       tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mask;

    // Counter: clear has priority, otherwise count while enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Compare mask covering the low DIV_BASE+div bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < CNT_W; i++) begin
            mask[i] = (i < (DIV_BASE + int'(div)));
        end
    end

    assign tick = en && ((cnt & mask) == mask);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: IDLE/RUN/PAUSE FSM driving a prescaled 2-bit
// step counter that is mapped onto two LEDs by a latched pattern mode.
// Optional feature macro: LED_SEQ_PAUSE_EN (PAUSE state and pause input).
// Without it, pause is ignored and the FSM only uses IDLE and RUN.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CNT_W    = 28,
    parameter int DIV_BASE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [1:0] div_sel,
    input  logic [1:0] mode,
    output logic [1:0] leds,
    output logic       tick,
    output logic       busy
);

    generate
        if (DIV_BASE + 3 > CNT_W) begin : g_bad_cfg
            $error("led_seq_ctrl: DIV_BASE+3 must not exceed CNT_W");
        end
    endgenerate

    state_t     state;
    state_t     state_nxt;
    logic [1:0] div_q;
    logic [1:0] mode_q;
    logic [1:0] step;
    logic       pause_cmd;
    logic       clr;
    logic       run;

`ifdef LED_SEQ_PAUSE_EN
    assign pause_cmd = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_cmd    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state with command priority stop > pause > start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!stop && !pause_cmd && start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (pause_cmd) begin
                    state_nxt = ST_PAUSE;
                end
            end
`ifdef LED_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start && !pause) begin
                    state_nxt = ST_RUN;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Any path into IDLE (including stop on a tick cycle) clears the counters.
    assign clr = (state_nxt == ST_IDLE);
    assign run = (state == ST_RUN);

    led_prescaler #(
        .CNT_W    (CNT_W),
        .DIV_BASE (DIV_BASE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (run),
        .div  (div_q),
        .tick (tick)
    );

    // Capture run configuration on IDLE -> RUN only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 2'd0;
            mode_q <= 2'd0;
        end else if (state == ST_IDLE && state_nxt == ST_RUN) begin
            div_q  <= div_sel;
            mode_q <= mode;
        end
    end

    // Step counter advances after each tick and wraps naturally at 2 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= 2'd0;
        end else if (clr) begin
            step <= 2'd0;
        end else if (tick) begin
            step <= step + 2'd1;
        end
    end

    // LED drive: dark in IDLE, otherwise the latched pattern of the step.
    always_comb begin
        leds = 2'b00;
        if (state != ST_IDLE) begin
            leds = led_pattern(mode_q, step);
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 28: prescaler counter width in bits.
REQ-002 Parameter DIV_BASE, default 24: log2 of the shortest tick period; DIV_BASE+3 SHALL be <= CNT_W (elaboration error otherwise).
REQ-003 clk  in  1  single clock; all state updates on the posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  level, sampled each cycle: begin a run from IDLE, or resume from PAUSE.
REQ-006 pause  in  1  level, sampled each cycle: freeze a run.
REQ-007 stop  in  1  level, sampled each cycle: abort to IDLE.
REQ-008 div_sel  in  2  tick period select; tick period = 2^(DIV_BASE+div_sel) cycles.
REQ-009 mode  in  2  LED pattern select (0 binary, 1 and/or, 2 walking, 3 blink).
REQ-010 leds  out  2  LED drive.
REQ-011 tick  out  1  one-cycle pulse per prescaler period while in RUN.
REQ-012 busy  out  1  high in RUN or PAUSE.

Function
REQ-013 The FSM SHALL have exactly 3 states: IDLE, RUN, PAUSE.
REQ-014 Command priority SHALL be stop > pause > start when several are asserted in the same cycle.
REQ-015 IDLE -> RUN on start; RUN -> PAUSE on pause; PAUSE -> RUN on start with pause low; RUN or PAUSE -> IDLE on stop; otherwise the state holds.
REQ-016 On IDLE -> RUN, div_sel and mode SHALL be latched (div_q, mode_q); changes to them during RUN or PAUSE SHALL be ignored.
REQ-017 In IDLE, the prescaler and the 2-bit step counter SHALL be held at 0.
REQ-018 In RUN, the prescaler SHALL increment by 1 every cycle, wrapping modulo 2^CNT_W.
REQ-019 In PAUSE, the prescaler, step counter and tick SHALL hold; tick SHALL be 0.
REQ-020 tick SHALL be 1 (combinational) when in RUN and the low DIV_BASE+div_q prescaler bits are all ones.
REQ-021 The step counter SHALL increment on the cycle after tick and wrap from 3 to 0.
REQ-022 The first tick after start SHALL occur 2^(DIV_BASE+div_q) cycles after entry to RUN.
REQ-023 leds SHALL be combinational from state, mode_q and step (s1 s0):
- IDLE: 00
- mode 0: {s1,s0}
- mode 1: {s1&s0, s1|s0}
- mode 2: s0 ? 10 : 01
- mode 3: s0 ? 11 : 00
REQ-024 A stop asserted in the same cycle as a tick SHALL return the block to IDLE with the step counter cleared; the tick SHALL have no effect.
REQ-025 A start asserted while in RUN SHALL be ignored and SHALL NOT restart the prescaler.

Reset
REQ-026 While rst is high: state = IDLE, prescaler = 0, step = 0, div_q = 0, mode_q = 0; outputs leds = 00, tick = 0, busy = 0; the block SHALL remain in this condition while rst is held.
REQ-027 An rst assertion mid-run SHALL take effect asynchronously, without waiting for a clock edge.

Configuration
REQ-028 Macro LED_SEQ_PAUSE_EN:
- Defined: PAUSE state and the pause input SHALL behave as in REQ-015 and REQ-019.
- Undefined: the PAUSE state SHALL NOT exist, pause SHALL be ignored, and start in RUN SHALL be ignored.

Structure
REQ-029 Package led_seq_pkg SHALL hold the state enum (IDLE/RUN/PAUSE) and the mode encoding constants.
REQ-030 The prescaler and tick compare SHALL be a sub-module named led_prescaler (ports: clk, rst, clr, en, div, tick).

Verification (CNT_W=8, DIV_BASE=2)
REQ-031 rst high, then released, no commands -> leds = 00, busy = 0, tick never asserted for 50 cycles.
REQ-032 start 1 cycle, div_sel = 0, mode = 0 -> tick every 4 cycles, first tick 4 cycles after RUN entry; leds sequence 01, 10, 11, 00.
REQ-033 mode = 1, div_sel = 1 -> tick every 8 cycles; leds sequence 01, 01, 11, 00; changing mode to 2 mid-run -> pattern unchanged.
REQ-034 pause in RUN -> tick = 0 and leds frozen for 20 cycles; start -> next tick occurs exactly at the remaining count (with LED_SEQ_PAUSE_EN defined).
REQ-035 stop and start asserted together in RUN -> IDLE, leds = 00, busy = 0; stop in the same cycle as a tick -> step = 0.
REQ-036 rst asserted mid-cycle in RUN -> leds = 00 and busy = 0 before the next clk edge.
